// File: rtl/regfile_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_stage
// Description : 2**ADDR_W x WIDTH register file with write-before-read bypass
//               and a stallable, flushable output pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [WIDTH-1:0]  rs_data,
    output logic [WIDTH-1:0]  rt_data,
    output logic [ADDR_W-1:0] rs_tag,
    output logic [ADDR_W-1:0] rt_tag,
    output logic              out_valid
);

    localparam int c_NREGS = 2 ** ADDR_W;

    logic [WIDTH-1:0]  r_regs [0:c_NREGS-1];
    logic [WIDTH-1:0]  r_rs_data;
    logic [WIDTH-1:0]  r_rt_data;
    logic [ADDR_W-1:0] r_rs_tag;
    logic [ADDR_W-1:0] r_rt_tag;
    logic              r_out_valid;

    logic              w_wr_ok;
    logic [WIDTH-1:0]  w_rs_val;
    logic [WIDTH-1:0]  w_rt_val;
    logic              w_rs_held_hit;
    logic              w_rt_held_hit;

    assign w_wr_ok = wr_en && (wr_addr != '0);

    // Register 0 is hardwired to zero, so the bypass can never return r0 data.
    always_comb begin
        w_rs_val = r_regs[rs_addr];
        if (rs_addr == '0)
            w_rs_val = '0;
        else if (w_wr_ok && (wr_addr == rs_addr))
            w_rs_val = wr_data;

        w_rt_val = r_regs[rt_addr];
        if (rt_addr == '0)
            w_rt_val = '0;
        else if (w_wr_ok && (wr_addr == rt_addr))
            w_rt_val = wr_data;
    end

    assign w_rs_held_hit = w_wr_ok && (wr_addr == r_rs_tag);
    assign w_rt_held_hit = w_wr_ok && (wr_addr == r_rt_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Held operands track writes to their tag so they never go stale in a stall.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_rs_tag    <= '0;
            r_rt_tag    <= '0;
            r_out_valid <= 1'b0;
        end else if (stall) begin
            if (w_rs_held_hit)
                r_rs_data <= wr_data;
            if (w_rt_held_hit)
                r_rt_data <= wr_data;
        end else begin
            r_rs_data   <= w_rs_val;
            r_rt_data   <= w_rt_val;
            r_rs_tag    <= rs_addr;
            r_rt_tag    <= rt_addr;
            r_out_valid <= in_valid;
        end
    end

    assign rs_data   = r_rs_data;
    assign rt_data   = r_rt_data;
    assign rs_tag    = r_rs_tag;
    assign rt_tag    = r_rt_tag;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
